// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU settles) -> RESP (held until consumed).
module alu_share_arbiter #(
  parameter int WIDTH = 6,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op1,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       ptr;
  logic       grant_id;
  logic       win;
  logic       accept;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b10)
      win = 1'b1;
    else if (req_valid == 2'b11)
      win = ptr;
  end

  // Gated by rst so no handshake is advertised while reset is being applied.
  assign accept    = (state == IDLE) && (|req_valid) && !rst;
  assign req_ready = accept ? (win ? 2'b10 : 2'b01) : '0;
  assign rsp_valid = (state == RESP) ? (grant_id ? 2'b10 : 2'b01) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      grant_id <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            alu_a    <= win ? req_a1  : req_a0;
            alu_b    <= win ? req_b1  : req_b0;
            alu_op   <= win ? req_op1 : req_op0;
            grant_id <= win;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= alu_out;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            ptr   <= ~grant_id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
